// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM states and parity_mode encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam logic [1:0] ParNone = 2'b00;
  localparam logic [1:0] ParEven = 2'b01;
  localparam logic [1:0] ParOdd  = 2'b10;

  // 2'b11 is treated like ParNone.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == ParEven) || (mode == ParOdd);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one tick every divisor+1 clocks, restartable via clear.
module uart_baud_gen #(
  parameter int unsigned DIV_BITS = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [DIV_BITS-1:0] divisor,
  output logic                tick
);

  logic [DIV_BITS-1:0] cnt;

  assign tick = (cnt == divisor);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_BITS'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an inline write FIFO; frame config is latched on each pop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DBIT     = 8,
  parameter int unsigned SB_TICK  = 16,
  parameter int unsigned DIV_BITS = 11,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DIV_BITS-1:0]      divisor,
  input  logic [1:0]               parity_mode,
  input  logic                     two_stop,
  input  logic                     din_valid,
  input  logic [DBIT-1:0]          din,
  output logic                     din_ready,
  output logic                     tx,
  output logic                     tx_busy,
  output logic                     tx_done_tick,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = AW + 1;
  localparam int unsigned TW   = $clog2(2 * SB_TICK);
  localparam int unsigned BW   = $clog2(DBIT);

  logic [DBIT-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CntW-1:0] count;
  logic            push, pop, tick, bit_last, stop_last;

  uart_state_e         state;
  logic [TW-1:0]       tick_cnt;
  logic [BW-1:0]       bit_idx;
  logic [DBIT-1:0]     shreg;
  logic [DIV_BITS-1:0] div_r;
  logic [1:0]          pmode_r;
  logic                two_stop_r;
  logic                par_r;

  assign din_ready  = (count < CntW'(DEPTH));
  assign fifo_count = count;

  assign bit_last  = tick && (tick_cnt == TW'(SB_TICK - 1));
  assign stop_last = tick && (tick_cnt == (two_stop_r ? TW'(2 * SB_TICK - 1) : TW'(SB_TICK - 1)));
  assign pop = (count != '0) && ((state == StIdle) || ((state == StStop) && stop_last));
  // A pop in the same clock frees a slot, so a write at full is still taken then.
  assign push = din_valid && (din_ready || pop);

  uart_baud_gen #(
    .DIV_BITS(DIV_BITS)
  ) u_baud_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (pop),
    .divisor(div_r),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StIdle;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
      tick_cnt     <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      div_r        <= '0;
      pmode_r      <= ParNone;
      two_stop_r   <= 1'b0;
      par_r        <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      if (pop) begin
        // A pop out of STOP also closes the previous frame.
        if (state == StStop) tx_done_tick <= 1'b1;
        state      <= StStart;
        tx         <= 1'b0;
        tx_busy    <= 1'b1;
        tick_cnt   <= '0;
        shreg      <= mem[rd_ptr];
        par_r      <= (^mem[rd_ptr]) ^ (parity_mode == ParOdd);
        div_r      <= divisor;
        pmode_r    <= parity_mode;
        two_stop_r <= two_stop;
      end else if (tick) begin
        unique case (state)
          StIdle: begin
            tick_cnt <= '0;
          end
          StStart: begin
            if (bit_last) begin
              state    <= StData;
              tx       <= shreg[0];
              tick_cnt <= '0;
              bit_idx  <= '0;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          StData: begin
            if (bit_last) begin
              tick_cnt <= '0;
              if (bit_idx == BW'(DBIT - 1)) begin
                if (parity_enabled(pmode_r)) begin
                  state <= StParity;
                  tx    <= par_r;
                end else begin
                  state <= StStop;
                  tx    <= 1'b1;
                end
              end else begin
                shreg   <= shreg >> 1;
                tx      <= shreg[1];
                bit_idx <= bit_idx + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          StParity: begin
            if (bit_last) begin
              state    <= StStop;
              tx       <= 1'b1;
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          StStop: begin
            if (stop_last) begin
              state        <= StIdle;
              tx_busy      <= 1'b0;
              tx_done_tick <= 1'b1;
              tick_cnt     <= '0;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          default: begin
            state <= StIdle;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: cycle-exact waveform checks against a frame model.
module tb_uart_tx_fifo;

  localparam int DBIT     = 8;
  localparam int SB_TICK  = 16;
  localparam int DIV_BITS = 11;
  localparam int DEPTH    = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [DIV_BITS-1:0] divisor;
  logic [1:0]          parity_mode;
  logic                two_stop;
  logic                din_valid;
  logic [DBIT-1:0]     din;
  logic                din_ready;
  logic                tx;
  logic                tx_busy;
  logic                tx_done_tick;
  logic [2:0]          fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] seq [6];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DBIT    (DBIT),
    .SB_TICK (SB_TICK),
    .DIV_BITS(DIV_BITS),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .divisor     (divisor),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .din_valid   (din_valid),
    .din         (din),
    .din_ready   (din_ready),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_done_tick(tx_done_tick),
    .fifo_count  (fifo_count)
  );

  // Bit k of a frame: start, data LSB first, optional parity, then stop bit(s).
  function automatic logic exp_bit(input logic [7:0] b, input logic [1:0] pm, input int k);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if ((pm == 2'b01 || pm == 2'b10) && k == 9) begin
      if (pm == 2'b01) return (ones % 2) == 1;
      return (ones % 2) == 0;
    end
    return 1'b1;
  endfunction

  function automatic int frame_bits(input logic [1:0] pm, input logic ts);
    return 1 + 8 + ((pm == 2'b01 || pm == 2'b10) ? 1 : 0) + (ts ? 2 : 1);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_now(input logic [7:0] b);
    din = b;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // Checks one frame cycle by cycle; returns at the negedge where tx_done_tick is due.
  task automatic watch_frame(input logic [7:0] b, input int dv, input logic [1:0] pm,
                             input logic ts, input bit wait_start, input string tag);
    int L, len, errs, first, w;
    L = SB_TICK * (dv + 1);
    len = L * frame_bits(pm, ts);
    errs = 0;
    first = -1;
    if (wait_start) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (tx !== 1'b0 && w < 5000);
      n_checks++;
      if (tx !== 1'b0) begin
        n_fail++;
        $display("FAIL %s start: tx=%b after %0d cycles, required 0", tag, tx, w);
        return;
      end
    end
    for (int c = 0; c < len; c++) begin
      if (tx !== exp_bit(b, pm, c / L) || tx_busy !== 1'b1 ||
          (c > 0 && tx_done_tick !== 1'b0)) begin
        if (errs == 0) first = c;
        errs++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL %s waveform: %0d bad cycles (first at cycle %0d, byte %h), required 0",
               tag, errs, first, b);
    end
    n_checks++;
    if (tx_done_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_tick: got %b at cycle %0d, required 1", tag, tx_done_tick, len);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 5;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset tx: got %b, required 1", tx); end
    if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b, required 0", tx_busy); end
    if (tx_done_tick !== 1'b0) begin
      n_fail++; $display("FAIL reset done: got %b, required 0", tx_done_tick);
    end
    if (fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL reset count: got %0d, required 0", fifo_count);
    end
    if (din_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset ready: got %b, required 1", din_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_8n1();
    do_reset();
    divisor = 11'd3; parity_mode = 2'b00; two_stop = 1'b0;
    fork
      write_now(8'h55);
      watch_frame(8'h55, 3, 2'b00, 1'b0, 1'b1, "8n1_55");
    join
    @(negedge clk);
  endtask

  task automatic test_parity_stop();
    do_reset();
    divisor = 11'd3; two_stop = 1'b0;
    parity_mode = 2'b01;
    fork
      write_now(8'h07);
      watch_frame(8'h07, 3, 2'b01, 1'b0, 1'b1, "even_07");
    join
    parity_mode = 2'b10;
    fork
      write_now(8'h07);
      watch_frame(8'h07, 3, 2'b10, 1'b0, 1'b1, "odd_07");
    join
    parity_mode = 2'b00; two_stop = 1'b1;
    fork
      write_now(8'hA3);
      watch_frame(8'hA3, 3, 2'b00, 1'b1, 1'b1, "two_stop");
    join
    two_stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_burst();
    int model_cnt;
    do_reset();
    divisor = 11'd0; parity_mode = 2'b00; two_stop = 1'b0;
    for (int i = 0; i < 6; i++) seq[i] = 8'($urandom);
    fork
      begin
        write_now(seq[0]);
        repeat (8) @(negedge clk);
        model_cnt = 0;
        for (int i = 1; i < 6; i++) begin
          din = seq[i];
          din_valid = 1'b1;
          n_checks++;
          if (din_ready !== (model_cnt < DEPTH)) begin
            n_fail++;
            $display("FAIL burst ready[%0d]: got %b, required %b", i, din_ready,
                     (model_cnt < DEPTH));
          end
          if (model_cnt < DEPTH) model_cnt++;
          @(negedge clk);
        end
        din_valid = 1'b0;
        n_checks++;
        if (fifo_count !== 3'(model_cnt)) begin
          n_fail++;
          $display("FAIL burst count: got %0d, required %0d", fifo_count, model_cnt);
        end
      end
      begin
        watch_frame(seq[0], 0, 2'b00, 1'b0, 1'b1, "burst0");
        for (int i = 1; i < 5; i++) watch_frame(seq[i], 0, 2'b00, 1'b0, 1'b0, "burst_b2b");
        n_checks++;
        if (tx_busy !== 1'b0 || tx !== 1'b1) begin
          n_fail++;
          $display("FAIL burst sixth_dropped: busy=%b tx=%b, required busy 0 tx 1", tx_busy, tx);
        end
      end
    join
    @(negedge clk);
  endtask

  task automatic test_full_pop();
    bit seen;
    do_reset();
    divisor = 11'd0; parity_mode = 2'b00; two_stop = 1'b0;
    for (int i = 0; i < 6; i++) seq[i] = 8'($urandom);
    fork
      begin
        write_now(seq[0]);
        repeat (8) @(negedge clk);
        for (int i = 1; i < 5; i++) write_now(seq[i]);
        din = seq[5];
        din_valid = 1'b1;
        seen = 1'b0;
        for (int w = 0; w < 400 && !seen; w++) begin
          @(posedge clk);
          #1;
          if (tx_done_tick === 1'b1) seen = 1'b1;
        end
        din_valid = 1'b0;
        n_checks += 2;
        if (!seen) begin
          n_fail++; $display("FAIL full_pop pop_seen: got 0, required 1");
        end
        if (fifo_count !== 3'd4) begin
          n_fail++; $display("FAIL full_pop count: got %0d, required 4", fifo_count);
        end
      end
      begin
        watch_frame(seq[0], 0, 2'b00, 1'b0, 1'b1, "full0");
        for (int i = 1; i < 6; i++) watch_frame(seq[i], 0, 2'b00, 1'b0, 1'b0, "full_order");
      end
    join
    @(negedge clk);
  endtask

  task automatic test_div_change();
    logic [7:0] a, b;
    do_reset();
    a = 8'($urandom); b = 8'($urandom);
    divisor = 11'd3; parity_mode = 2'b00; two_stop = 1'b0;
    fork
      begin
        write_now(a);
        write_now(b);
        repeat (200) @(negedge clk);
        divisor = 11'd7; parity_mode = 2'b01; two_stop = 1'b1;
      end
      begin
        watch_frame(a, 3, 2'b00, 1'b0, 1'b1, "divchg_cur");
        watch_frame(b, 7, 2'b01, 1'b1, 1'b0, "divchg_next");
      end
    join
    parity_mode = 2'b00; two_stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int w, bad_done, bad_tx;
    do_reset();
    divisor = 11'd3; parity_mode = 2'b00; two_stop = 1'b0;
    write_now(8'hC3);
    write_now(8'h3C);
    w = 0;
    while (tx !== 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (200) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks += 4;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL midreset tx: got %b, required 1", tx); end
    if (tx_busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset busy: got %b, required 0", tx_busy);
    end
    if (fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL midreset count: got %0d, required 0", fifo_count);
    end
    if (din_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset ready: got %b, required 1", din_ready);
    end
    reset = 1'b0;
    bad_done = 0; bad_tx = 0;
    for (int c = 0; c < 800; c++) begin
      if (tx_done_tick !== 1'b0) bad_done++;
      if (tx !== 1'b1) bad_tx++;
      @(negedge clk);
    end
    n_checks += 2;
    if (bad_done != 0) begin
      n_fail++; $display("FAIL midreset no_done: %0d done cycles, required 0", bad_done);
    end
    if (bad_tx != 0) begin
      n_fail++; $display("FAIL midreset idle_line: %0d low cycles, required 0", bad_tx);
    end
  endtask

  task automatic test_random();
    int dv;
    logic [1:0] pm;
    logic ts;
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      dv = int'($urandom_range(0, 2));
      pm = 2'($urandom_range(0, 3));
      ts = 1'($urandom_range(0, 1));
      b  = 8'($urandom);
      divisor = DIV_BITS'(dv); parity_mode = pm; two_stop = ts;
      fork
        write_now(b);
        watch_frame(b, dv, pm, ts, 1'b1, "random");
      join
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    divisor = '0;
    parity_mode = 2'b00;
    two_stop = 1'b0;
    din_valid = 1'b0;
    din = '0;
    test_reset();
    test_basic_8n1();
    test_parity_stop();
    test_burst();
    test_full_pop();
    test_div_change();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
